gpr_bus_master: RTL

//  Initiator side of the GPR bus: converts single-word cmd_valid/cmd_ready requests into
//  cs/write/req/rdy bus transactions against the gpr register file over a shared tri-state

---
 rtl/gpr_bus_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gpr_bus_master.sv
// gpr_bus_master
//   Initiator side of the GPR bus. Accepts one single-word command at a time on a
//   valid/ready port, runs a cs/req/write/rdy transaction against the gpr register
//   file over a shared tri-state data bus, and reports completion with a one-cycle
//   resp pulse. A per-wait-state cycle counter aborts the transaction if the
//   responder never answers.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only in IDLE and does not depend on
//   cmd_valid. A source whose command is not taken must hold it (valid, write,
//   addr, wdata) unchanged until it is taken.
//
// Ports
//   clk, rst      clock (posedge) and synchronous active-high reset
//   cmd_valid     in   request present
//   cmd_ready     out  master idle, command accepted on valid&ready
//   cmd_write     in   1 = write, 0 = read
//   cmd_addr      in   target word address
//   cmd_wdata     in   write data
//   resp_valid    out  one-cycle pulse, transaction finished
//   resp_error    out  qualifies resp_valid, 1 = timeout abort
//   resp_rdata    out  read data, valid with resp_valid on non-error reads
//   bus_cs        out  chip select to gpr
//   bus_req       out  request strobe, identical to bus_cs
//   bus_write     out  1 = write cycle
//   bus_address   out  registered address
//   bus_rdy       in   gpr ready, high = idle, low = busy
//   bus_data      inout shared data bus, driven only during a write cycle
//   dbg_state     out  current FSM state encoding

module gpr_bus_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  bus_cs,
    output logic                  bus_req,
    output logic                  bus_write,
    output logic [ADDR_WIDTH-1:0] bus_address,
    input  logic                  bus_rdy,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4,
        ABORT     = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic                  cs_q, cs_next;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;
    logic                  capture;

    assign accept = cmd_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cs_q  <= cs_next;
            if (accept) begin
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (capture) begin
                resp_rdata <= bus_data;
            end
        end
    end

    // cs is registered: it rises on the edge leaving START and falls on the edge
    // leaving a wait state, so the bus is stable from START through WAIT_DONE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cs_next    = cs_q;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = START;
                end
            end
            START: begin
                cs_next    = 1'b1;
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus_rdy) begin
                    cnt_next   = '0;
                    state_next = WAIT_DONE;
                end else if (cnt >= TMO) begin
                    cs_next    = 1'b0;
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus_rdy) begin
                    capture    = !wr_q;
                    cs_next    = 1'b0;
                    state_next = DONE;
                end else if (cnt >= TMO) begin
                    cs_next    = 1'b0;
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready   = (state == IDLE);
    assign resp_valid  = (state == DONE) || (state == ABORT);
    assign resp_error  = (state == ABORT);
    assign bus_cs      = cs_q;
    assign bus_req     = cs_q;
    assign bus_write   = wr_q;
    assign bus_address = addr_q;
    assign dbg_state   = state;

    // Drive only during an active write cycle; a read leaves the bus to the gpr.
    assign bus_data = (cs_q && wr_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
